// File: rtl/sudoku_pkg.sv
// Shared types and helpers for the 4x4 Sudoku game controller:
// FSM state codes, clue counts, base-grid value and cell index.
package sudoku_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_GEN   = 4'd1,
    S_BOARD = 4'd2,
    S_DIFF  = 4'd3,
    S_ROW   = 4'd4,
    S_COL   = 4'd5,
    S_VAL   = 4'd6,
    S_WRITE = 4'd7,
    S_CHECK = 4'd8,
    S_WIN   = 4'd9,
    S_LOSE  = 4'd10
  } state_t;

  localparam logic [3:0] CLUES_EASY = 4'd10;
  localparam logic [3:0] CLUES_MED  = 4'd8;
  localparam logic [3:0] CLUES_HARD = 4'd6;

  function automatic logic [3:0] clue_count(input logic [1:0] d);
    if (d[1])      return CLUES_HARD;
    else if (d[0]) return CLUES_MED;
    else           return CLUES_EASY;
  endfunction

  // ((2r + r/2 + c) mod 4) + 1, done in 2-bit wraparound
  function automatic logic [2:0] base_val(input logic [1:0] r,
                                          input logic [1:0] c);
    logic [1:0] s;
    s = {r[0], 1'b0} + {1'b0, r[1]} + c;
    return {1'b0, s} + 3'd1;
  endfunction

  function automatic logic [3:0] cell_idx(input logic [1:0] r,
                                          input logic [1:0] c);
    return {r, c};
  endfunction

endpackage

// File: rtl/sudoku_board_gen.sv
// Combinational solution-board generator.
// Ports: setup, a (seeds) -> cells[16] (3-bit values, index 4*row+col).
module sudoku_board_gen
  import sudoku_pkg::*;
(
  input  logic [3:0]        setup,
  input  logic [3:0]        a,
  output logic [15:0][2:0]  cells
);

  logic [1:0] r2, c2, x, y, rr, cc;
  logic [2:0] d;

  // Each output cell is traced back through the swaps to its
  // source cell in the base grid; all swaps are self-inverse.
  always_comb begin
    cells = '0;
    r2 = '0;
    c2 = '0;
    x  = '0;
    y  = '0;
    rr = '0;
    cc = '0;
    d  = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        r2 = 2'(r);
        c2 = 2'(c);
        x  = r2 ^ {a[2], 1'b0};
        rr = x ^ {1'b0, (x[1] ? setup[3] : setup[2])};
        y  = c2 ^ {a[3], 1'b0};
        cc = y ^ {1'b0, (y[1] ? a[1] : a[0])};
        d  = base_val(rr, cc);
        cells[cell_idx(r2, c2)] =
          ((d + {1'b0, setup[1:0]} - 3'd1) & 3'd3) + 3'd1;
      end
    end
  end

endmodule

// File: rtl/sudoku_top_module.sv
// 4x4 Sudoku game controller: FSM, enter edge detect, boards, compare.
// Ports: clock/reset, enter, seeds, 2-bit entry; state, flags, boards.
module sudoku_top_module
  import sudoku_pkg::*;
(
  input  logic       in_clka,
  input  logic       in_restart_n,
  input  logic       in_enter,
  input  logic [3:0] in_rand_setup,
  input  logic [3:0] in_rand_A,
  input  logic [3:0] in_rand_B,
  input  logic [1:0] in_diff_cell_val,
  output logic [3:0] out_state,
  output logic       out_gen_rand_flag,
  output logic       out_set_board_flag,
  output logic       out_set_diff_flag,
  output logic       out_row_flag,
  output logic       out_col_flag,
  output logic       out_val_flag,
  output logic       out_check_flag,
  output logic [15:0] out_fill_flag,
  output logic       out_solved,
  output logic [2:0] out_user_board_0,  out_user_board_1,
  output logic [2:0] out_user_board_2,  out_user_board_3,
  output logic [2:0] out_user_board_4,  out_user_board_5,
  output logic [2:0] out_user_board_6,  out_user_board_7,
  output logic [2:0] out_user_board_8,  out_user_board_9,
  output logic [2:0] out_user_board_10, out_user_board_11,
  output logic [2:0] out_user_board_12, out_user_board_13,
  output logic [2:0] out_user_board_14, out_user_board_15,
  output logic [2:0] out_real_board_0,  out_real_board_1,
  output logic [2:0] out_real_board_2,  out_real_board_3,
  output logic [2:0] out_real_board_4,  out_real_board_5,
  output logic [2:0] out_real_board_6,  out_real_board_7,
  output logic [2:0] out_real_board_8,  out_real_board_9,
  output logic [2:0] out_real_board_10, out_real_board_11,
  output logic [2:0] out_real_board_12, out_real_board_13,
  output logic [2:0] out_real_board_14, out_real_board_15
);

  state_t state, nxt;
  logic enter_q, enter_edge;
  logic [3:0] setup_q, a_q, b_q;
  logic [1:0] row_q, col_q, val_q;
  logic [15:0] given, given_nxt, fill, wr_hot;
  logic [15:0][2:0] user, sol, gen_cells;
  logic [3:0] wr_idx, clues;
  logic all_after, match;

  sudoku_board_gen u_gen (
    .setup (setup_q),
    .a     (a_q),
    .cells (gen_cells)
  );

  assign enter_edge = in_enter & ~enter_q;
  assign wr_idx     = cell_idx(row_q, col_q);
  assign wr_hot     = 16'd1 << wr_idx;
  // given cells are never zero, so the written cell is always filled
  assign all_after  = &(fill | wr_hot);
  assign match      = (user == sol);
  assign clues      = clue_count(in_diff_cell_val);

  always_comb begin
    fill      = '0;
    given_nxt = '0;
    for (int i = 0; i < 16; i++) begin
      fill[i]      = |user[i];
      given_nxt[i] = (4'(5 * i) + b_q) < clues;
    end
  end

  always_ff @(posedge in_clka or negedge in_restart_n) begin
    if (!in_restart_n) state <= S_IDLE;
    else               state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (enter_edge) nxt = S_GEN;
      S_GEN:   nxt = S_BOARD;
      S_BOARD: nxt = S_DIFF;
      S_DIFF:  if (enter_edge) nxt = S_ROW;
      S_ROW:   if (enter_edge) nxt = S_COL;
      S_COL:   if (enter_edge) nxt = S_VAL;
      S_VAL:   if (enter_edge) nxt = S_WRITE;
      S_WRITE: nxt = all_after ? S_CHECK : S_ROW;
      S_CHECK: nxt = match ? S_WIN : S_LOSE;
      S_WIN,
      S_LOSE:  if (enter_edge) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    out_gen_rand_flag  = 1'b0;
    out_set_board_flag = 1'b0;
    out_set_diff_flag  = 1'b0;
    out_row_flag       = 1'b0;
    out_col_flag       = 1'b0;
    out_val_flag       = 1'b0;
    out_check_flag     = 1'b0;
    out_solved         = 1'b0;
    unique case (1'b1)
      state == S_GEN:   out_gen_rand_flag  = 1'b1;
      state == S_BOARD: out_set_board_flag = 1'b1;
      state == S_DIFF:  out_set_diff_flag  = 1'b1;
      state == S_ROW:   out_row_flag       = 1'b1;
      state == S_COL:   out_col_flag       = 1'b1;
      state == S_VAL:   out_val_flag       = 1'b1;
      state == S_CHECK: out_check_flag     = 1'b1;
      state == S_WIN:   out_solved         = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge in_clka or negedge in_restart_n) begin
    if (!in_restart_n) begin
      enter_q <= 1'b0;
      setup_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      val_q   <= '0;
      given   <= '0;
      user    <= '0;
      sol     <= '0;
    end else begin
      enter_q <= in_enter;
      unique case (state)
        S_GEN: begin
          setup_q <= in_rand_setup;
          a_q     <= in_rand_A;
          b_q     <= in_rand_B;
        end
        S_BOARD: sol <= gen_cells;
        S_DIFF: if (enter_edge) begin
          given <= given_nxt;
          for (int i = 0; i < 16; i++)
            user[i] <= given_nxt[i] ? sol[i] : 3'd0;
        end
        S_ROW: if (enter_edge) row_q <= in_diff_cell_val;
        S_COL: if (enter_edge) col_q <= in_diff_cell_val;
        S_VAL: if (enter_edge) val_q <= in_diff_cell_val;
        S_WRITE: if (!given[wr_idx])
          user[wr_idx] <= {1'b0, val_q} + 3'd1;
        default: ;
      endcase
    end
  end

  assign out_state     = state;
  assign out_fill_flag = fill;

  assign {out_user_board_15, out_user_board_14, out_user_board_13,
          out_user_board_12, out_user_board_11, out_user_board_10,
          out_user_board_9,  out_user_board_8,  out_user_board_7,
          out_user_board_6,  out_user_board_5,  out_user_board_4,
          out_user_board_3,  out_user_board_2,  out_user_board_1,
          out_user_board_0} = user;

  assign {out_real_board_15, out_real_board_14, out_real_board_13,
          out_real_board_12, out_real_board_11, out_real_board_10,
          out_real_board_9,  out_real_board_8,  out_real_board_7,
          out_real_board_6,  out_real_board_5,  out_real_board_4,
          out_real_board_3,  out_real_board_2,  out_real_board_1,
          out_real_board_0} = sol;

endmodule

// File: tb/tb_sudoku_top_module.sv
// Self-checking bench for sudoku_top_module: directed games plus
// random-seed games against a board model built by moving rows/cols.
module tb_sudoku_top_module;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enter = 1'b0;
  logic [3:0] r_setup = '0, r_a = '0, r_b = '0;
  logic [1:0] dcv = '0;
  logic [3:0] st;
  logic f_gen, f_board, f_diff, f_row, f_col, f_val, f_chk;
  logic [15:0] fill;
  logic solved;
  logic [2:0] u0, u1, u2, u3, u4, u5, u6, u7;
  logic [2:0] u8, u9, u10, u11, u12, u13, u14, u15;
  logic [2:0] s0, s1, s2, s3, s4, s5, s6, s7;
  logic [2:0] s8, s9, s10, s11, s12, s13, s14, s15;
  logic [47:0] dut_user, dut_sol;
  logic [6:0] flags;

  int checks = 0;
  int errors = 0;
  int mr[16];
  int mu[16];
  bit mg[16];

  always #5 clk = ~clk;

  sudoku_top_module dut (
    .in_clka(clk), .in_restart_n(rst_n), .in_enter(enter),
    .in_rand_setup(r_setup), .in_rand_A(r_a), .in_rand_B(r_b),
    .in_diff_cell_val(dcv), .out_state(st),
    .out_gen_rand_flag(f_gen), .out_set_board_flag(f_board),
    .out_set_diff_flag(f_diff), .out_row_flag(f_row),
    .out_col_flag(f_col), .out_val_flag(f_val),
    .out_check_flag(f_chk), .out_fill_flag(fill),
    .out_solved(solved),
    .out_user_board_0(u0), .out_user_board_1(u1),
    .out_user_board_2(u2), .out_user_board_3(u3),
    .out_user_board_4(u4), .out_user_board_5(u5),
    .out_user_board_6(u6), .out_user_board_7(u7),
    .out_user_board_8(u8), .out_user_board_9(u9),
    .out_user_board_10(u10), .out_user_board_11(u11),
    .out_user_board_12(u12), .out_user_board_13(u13),
    .out_user_board_14(u14), .out_user_board_15(u15),
    .out_real_board_0(s0), .out_real_board_1(s1),
    .out_real_board_2(s2), .out_real_board_3(s3),
    .out_real_board_4(s4), .out_real_board_5(s5),
    .out_real_board_6(s6), .out_real_board_7(s7),
    .out_real_board_8(s8), .out_real_board_9(s9),
    .out_real_board_10(s10), .out_real_board_11(s11),
    .out_real_board_12(s12), .out_real_board_13(s13),
    .out_real_board_14(s14), .out_real_board_15(s15)
  );

  assign dut_user = {u15, u14, u13, u12, u11, u10, u9, u8,
                     u7, u6, u5, u4, u3, u2, u1, u0};
  assign dut_sol  = {s15, s14, s13, s12, s11, s10, s9, s8,
                     s7, s6, s5, s4, s3, s2, s1, s0};
  assign flags = {f_gen, f_board, f_diff, f_row, f_col, f_val, f_chk};

  task automatic chk(input string tag, input logic [63:0] o,
                     input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Reference: build the grid, then physically swap rows/cols.
  task automatic build(input logic [3:0] s, input logic [3:0] a,
                       input logic [3:0] b, input logic [1:0] d);
    int g[4][4];
    int t, n;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        g[r][c] = ((2 * r + r / 2 + c) % 4) + 1;
        g[r][c] = ((g[r][c] - 1 + int'(s[1:0])) % 4) + 1;
      end
    for (int c = 0; c < 4; c++) begin
      if (s[2]) begin t = g[0][c]; g[0][c] = g[1][c]; g[1][c] = t; end
      if (s[3]) begin t = g[2][c]; g[2][c] = g[3][c]; g[3][c] = t; end
    end
    for (int r = 0; r < 4; r++) begin
      if (a[0]) begin t = g[r][0]; g[r][0] = g[r][1]; g[r][1] = t; end
      if (a[1]) begin t = g[r][2]; g[r][2] = g[r][3]; g[r][3] = t; end
    end
    if (a[2])
      for (int c = 0; c < 4; c++) begin
        t = g[0][c]; g[0][c] = g[2][c]; g[2][c] = t;
        t = g[1][c]; g[1][c] = g[3][c]; g[3][c] = t;
      end
    if (a[3])
      for (int r = 0; r < 4; r++) begin
        t = g[r][0]; g[r][0] = g[r][2]; g[r][2] = t;
        t = g[r][1]; g[r][1] = g[r][3]; g[r][3] = t;
      end
    n = (d == 2'd0) ? 10 : (d == 2'd1) ? 8 : 6;
    for (int i = 0; i < 16; i++) begin
      mr[i] = g[i / 4][i % 4];
      mg[i] = ((5 * i + int'(b)) % 16) < n;
      mu[i] = mg[i] ? mr[i] : 0;
    end
  endtask

  function automatic logic [47:0] pk_real();
    logic [47:0] p = '0;
    for (int i = 0; i < 16; i++) p[3*i +: 3] = 3'(mr[i]);
    return p;
  endfunction

  function automatic logic [47:0] pk_user();
    logic [47:0] p = '0;
    for (int i = 0; i < 16; i++) p[3*i +: 3] = 3'(mu[i]);
    return p;
  endfunction

  function automatic logic [15:0] m_fill();
    logic [15:0] f = '0;
    for (int i = 0; i < 16; i++) f[i] = (mu[i] != 0);
    return f;
  endfunction

  // One rising edge with enter high, then one with it low.
  task automatic press(input logic [1:0] v);
    dcv = v;
    enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    @(negedge clk);
  endtask

  task automatic start(input logic [3:0] s, input logic [3:0] a,
                       input logic [3:0] b, input logic [1:0] d);
    build(s, a, b, d);
    r_setup = s; r_a = a; r_b = b;
    enter = 1'b1;
    @(negedge clk);
    chk("st_gen", st, 1);
    chk("flags_gen", flags, 7'b1000000);
    enter = 1'b0;
    @(negedge clk);
    chk("st_board", st, 2);
    @(negedge clk);
    chk("st_diff", st, 3);
    chk("real_board", dut_sol, pk_real());
    press(d);
    chk("st_row", st, 4);
    chk("user_init", dut_user, pk_user());
    chk("fill_init", fill, m_fill());
  endtask

  task automatic play(input logic [3:0] s, input logic [3:0] a,
                      input logic [3:0] b, input logic [1:0] d,
                      input bit bad);
    int gi, last;
    logic [1:0] v;
    bit win;
    start(s, a, b, d);
    gi = -1; last = 0;
    for (int i = 15; i >= 0; i--) if (mg[i]) gi = i;
    for (int i = 0; i < 16; i++) if (!mg[i]) last = i;
    press(2'(gi / 4)); press(2'(gi % 4)); press(2'(mr[gi] % 4));
    chk("st_given_wr", st, 4);
    chk("user_given_wr", dut_user, pk_user());
    for (int i = 0; i < 16; i++) begin
      if (!mg[i]) begin
        v = (bad && i == last) ? 2'(mr[i] % 4) : 2'(mr[i] - 1);
        press(2'(i / 4)); press(2'(i % 4)); press(v);
        mu[i] = int'(v) + 1;
        chk("user_wr", dut_user, pk_user());
        chk("st_after_wr", st, (i == last) ? 8 : 4);
      end
    end
    win = 1'b1;
    for (int i = 0; i < 16; i++) if (mu[i] != mr[i]) win = 1'b0;
    @(negedge clk);
    chk("st_result", st, win ? 9 : 10);
    chk("solved", solved, win);
    press(2'd0);
    chk("st_idle", st, 0);
  endtask

  initial begin
    logic [47:0] exp0;
    int tab[16] = '{1, 2, 3, 4, 3, 4, 1, 2, 2, 3, 4, 1, 4, 1, 2, 3};
    #2;
    chk("rst_state", st, 0);
    chk("rst_user", dut_user, 48'd0);
    chk("rst_real", dut_sol, 48'd0);
    chk("rst_flags", flags, 7'd0);
    chk("rst_fill", fill, 16'd0);
    chk("rst_solved", solved, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    exp0 = '0;
    for (int i = 0; i < 16; i++) exp0[3*i +: 3] = 3'(tab[i]);
    start(4'd0, 4'd0, 4'd0, 2'd0);
    chk("base_board", dut_sol, exp0);
    chk("base_fill", fill, 16'h6DB3);
    press(2'd0); press(2'd2); press(2'd2);
    chk("cell2", u2, 3'd3);
    chk("cell2_st", st, 4);
    press(2'd0); press(2'd0); press(2'd3);
    chk("given0", u0, 3'd1);
    press(2'd0);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    @(negedge clk);

    play(4'd0, 4'd0, 4'd0, 2'd0, 1'b0);
    play(4'd0, 4'd0, 4'd0, 2'd0, 1'b1);
    for (int k = 0; k < 8; k++)
      play(4'($urandom), 4'($urandom), 4'($urandom),
           2'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));

    start(4'($urandom), 4'($urandom), 4'($urandom), 2'd1);
    enter = 1'b1;
    repeat (3) @(negedge clk);
    enter = 1'b0;
    @(negedge clk);
    chk("hold_one_adv", st, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", st, 0);
    chk("mid_rst_user", dut_user, 48'd0);
    chk("mid_rst_real", dut_sol, 48'd0);
    chk("mid_rst_flags", flags, 7'd0);
    chk("mid_rst_fill", fill, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_state", st, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/sudoku_top_module.md
# sudoku_top_module

4x4 Sudoku game controller; this is the top-level game block. It builds a solution board from random seeds, blanks cells according to the chosen difficulty, and accepts row/column/value entries from the player. When every cell is filled it checks the player board against the solution and reports win or lose. Both boards and all phase flags are exported for display and debug.

## Interface
- No parameters. Board size is fixed at 4x4 with values 1..4; code 0 means an empty cell.
- in_clka  in  1  single system clock; all state changes on its rising edge.
- in_restart_n  in  1  asynchronous, active-low reset; returns the block to IDLE.
- in_enter  in  1  player confirm button; only its rising edge is acted on.
- in_rand_setup  in  4  seed: digit rotation and row swaps.
- in_rand_A  in  4  seed: column, band and stack swaps.
- in_rand_B  in  4  seed: clue-mask offset.
- in_diff_cell_val  in  2  difficulty, row, column or value, depending on state.
- out_state  out  4  current FSM state code.
- out_gen_rand_flag, out_set_board_flag, out_set_diff_flag, out_row_flag, out_col_flag, out_val_flag, out_check_flag  out  1 each  high while in the matching state.
- out_fill_flag  out  16  bit i high when user cell i is non-zero.
- out_solved  out  1  high in WIN.
- out_user_board_0..15  out  3 each  player board; cell i = 4*row+col.
- out_real_board_0..15  out  3 each  solution board.

## Operation
- Edge detect: enter_edge = in_enter & ~enter_q, where enter_q is a registered copy of in_enter. Holding in_enter high causes exactly one advance.
- State codes:
  - 0 IDLE
  - 1 GEN_RAND
  - 2 SET_BOARD
  - 3 SET_DIFF
  - 4 ROW
  - 5 COL
  - 6 VAL
  - 7 WRITE
  - 8 CHECK
  - 9 WIN
  - 10 LOSE
  - Codes 11-15 are illegal and go to IDLE.
- IDLE -> GEN_RAND on enter_edge.
- GEN_RAND: latch in_rand_setup, in_rand_A and in_rand_B; go to SET_BOARD after 1 cycle.
- SET_BOARD: load the real board from the latched seeds; go to SET_DIFF after 1 cycle.
- Base grid: base[r][c] = ((2r + r/2 + c) mod 4) + 1. Rows are 1234 / 3412 / 2341 / 4123.
- Transforms are applied in this order:
  1. Digit rotation: d -> ((d-1+setup[1:0]) mod 4) + 1.
  2. setup[2] swaps rows 0/1; setup[3] swaps rows 2/3.
  3. A[0] swaps cols 0/1; A[1] swaps cols 2/3.
  4. A[2] swaps bands (rows 0-1 with rows 2-3); A[3] swaps stacks (cols 0-1 with cols 2-3).
- SET_DIFF, on enter_edge:
  - Difficulty from in_diff_cell_val: 00 gives N=10 clues, 01 gives N=8, 1x gives N=6.
  - Cell i is a given iff ((5*i + rand_B) mod 16) < N, so there are exactly N givens.
  - User board is loaded with real values at givens and 0 elsewhere; the given mask is stored; go to ROW.
- ROW, then COL, then VAL: each latches in_diff_cell_val on enter_edge and advances.
- WRITE (1 cycle):
  - If cell 4*row+col is not a given, user cell <= val+1; a given cell is left unchanged.
  - Then go to CHECK if all 16 user cells are non-zero (evaluated after the write), else to ROW.
- CHECK (1 cycle): go to WIN if the user board equals the real board in all 16 cells, else to LOSE.
- WIN and LOSE hold until enter_edge, then go to IDLE. Boards keep their values until the next SET_BOARD / SET_DIFF.
- A filled, non-given cell may be overwritten while play continues.

## Timing
- Reset values: state IDLE (0), both boards all 0, given mask 0, latched seeds 0, enter_q 0, every flag 0, out_solved 0.
- Reset is accepted in any state, including mid-entry or CHECK. No partial write may survive reset.
- All outputs are registered or decoded from registered state; there is no combinational path from an input to an output.
- From the cycle IDLE sees enter_edge, SET_DIFF is reached 3 rising edges later.
- Filling the last cell: WRITE -> CHECK -> WIN/LOSE takes 2 cycles.
- An enter edge in a 1-cycle auto state (GEN_RAND, SET_BOARD, WRITE, CHECK) is ignored; enter_q still updates.

## Structure
- Package sudoku_pkg holds: state enum, difficulty clue counts (10/8/6), the base-grid function and the cell index helper.
- One sub-module, sudoku_board_gen: purely combinational, maps (setup, A) to 16 solution cells.
- The top level contains the FSM, the edge detector, the board registers and the compare logic.

## Test plan
- Reset, then enter pulse with setup=0, A=0, B=0 -> states 1, 2, 3. Real board must be 1,2,3,4,3,4,1,2,2,3,4,1,4,1,2,3.
- From that board, diff=00 -> givens at cells 0,1,4,5,7,8,10,11,13,14; fill_flag=16'h6DB3; state 4.
- Enter row 0, col 2, val 2 -> user_board_2=3, state back to 4. Then fill cells 3,6,9,12,15 correctly -> CHECK, then WIN, out_solved=1.
- Same flow, but enter a wrong value at cell 15 (val 0 instead of 2) -> LOSE (10), out_solved=0.
- Attempt to write given cell 0 with val 3 -> user_board_0 stays 1.
- Hold in_enter high for 3 cycles in ROW -> only one advance. Deassert in_restart_n mid-COL -> state 0 and all outputs 0 immediately.
